// File: rtl/fmadd_round_pipe.sv
// fmadd_round_pipe: two-stage rounding back end for a fused multiply-add.
// S1 decodes the unrounded product and decides whether to increment.
// S2 performs the increment and exponent adjustment, then applies the
// overflow substitution and builds the flags.
// Each stage has a valid register. Backpressure ripples back from out_ready.
module fmadd_round_pipe #(
   parameter  int FW    = 23,
   parameter  int EW    = 8,
   parameter  int TAG_W = 4,
   localparam int SW    = 2*FW+2,
   localparam int IW    = 1+(EW+1)+SW,
   localparam int OW    = 1+EW+FW
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    in_no,
   input  logic             in_sticky,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OW-1:0]    out_no,
   output logic [2:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_rm_err
);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // ---------------- handshake ----------------
   logic s1_valid_reg;
   logic s2_valid_reg;
   logic s2_advance;
   logic accept;

   assign s2_advance = ~s2_valid_reg | out_ready;
   // Gated by rst_l so that nothing is taken while reset is held.
   assign in_ready   = rst_l & (~s1_valid_reg | s2_advance);
   assign accept     = in_valid & in_ready;
   assign out_valid  = s2_valid_reg;

   // ---------------- S1 decode ----------------
   logic          sign_in;
   logic [EW:0]   exp_in;
   logic [SW-1:0] sig_in;
   logic [FW:0]   k_in;
   logic          g_bit, r_bit, s_bit, x_bit;
   logic          inc_next, to_inf_next, rm_err_next;

   assign sign_in = in_no[IW-1];
   assign exp_in  = in_no[IW-2 -: EW+1];
   assign sig_in  = in_no[SW-1:0];
   assign k_in    = sig_in[SW-1:FW+1];
   assign g_bit   = sig_in[FW];
   assign r_bit   = sig_in[FW-1];
   assign s_bit   = |sig_in[FW-2:0];
   assign x_bit   = g_bit | r_bit | s_bit | in_sticky;

   // Increment decision and overflow target (infinity vs max normal) per mode.
   always_comb begin
      inc_next    = g_bit & (r_bit | s_bit | in_sticky | k_in[0]);
      to_inf_next = 1'b1;
      rm_err_next = 1'b0;
      case (in_rm)
         RM_RNE: ;
         RM_RTZ: begin
            inc_next    = 1'b0;
            to_inf_next = 1'b0;
         end
         RM_RDN: begin
            inc_next    = x_bit & sign_in;
            to_inf_next = sign_in;
         end
         RM_RUP: begin
            inc_next    = x_bit & ~sign_in;
            to_inf_next = ~sign_in;
         end
         RM_RMM: inc_next = g_bit;
         default: rm_err_next = 1'b1;   // reserved codes round as RNE
      endcase
   end

   logic             s1_sign_reg;
   logic [EW:0]      s1_exp_reg;
   logic [FW:0]      s1_k_reg;
   logic             s1_inc_reg;
   logic             s1_inexact_reg;
   logic             s1_to_inf_reg;
   logic             s1_rm_err_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   // S1 register: valid follows the handshake, payload loads on acceptance.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         s1_valid_reg   <= 1'b0;
         s1_sign_reg    <= 1'b0;
         s1_exp_reg     <= '0;
         s1_k_reg       <= '0;
         s1_inc_reg     <= 1'b0;
         s1_inexact_reg <= 1'b0;
         s1_to_inf_reg  <= 1'b0;
         s1_rm_err_reg  <= 1'b0;
         s1_tag_reg     <= '0;
      end else begin
         if (in_ready)
            s1_valid_reg <= in_valid;
         if (accept) begin
            s1_sign_reg    <= sign_in;
            s1_exp_reg     <= exp_in;
            s1_k_reg       <= k_in;
            s1_inc_reg     <= inc_next;
            s1_inexact_reg <= x_bit;
            s1_to_inf_reg  <= to_inf_next;
            s1_rm_err_reg  <= rm_err_next;
            s1_tag_reg     <= in_tag;
         end
      end
   end

   // ---------------- S2 add / exceptions ----------------
   logic [FW+1:0] kr;
   logic          carry;
   logic          bump;
   logic [EW-1:0] er;
   logic [FW-1:0] frac;
   logic          of_flag;
   logic          nx_flag;
   logic          uf_flag;
   logic [OW-1:0] result;

   // Rounded significand, exponent bump on carry or subnormal-to-normal.
   always_comb begin
      kr      = {1'b0, s1_k_reg} + {{(FW+1){1'b0}}, s1_inc_reg};
      carry   = kr[FW+1];
      bump    = carry | (~s1_k_reg[FW] & kr[FW]);
      er      = s1_exp_reg[EW-1:0] + {{(EW-1){1'b0}}, bump};
      frac    = carry ? '0 : kr[FW-1:0];
      of_flag = s1_exp_reg[EW] | (&s1_exp_reg[EW-1:0]) | (&er);
      nx_flag = s1_inexact_reg | of_flag;
      uf_flag = (er == '0) & nx_flag & ~of_flag;
      if (!of_flag)
         result = {s1_sign_reg, er, frac};
      else if (s1_to_inf_reg)
         result = {s1_sign_reg, {EW{1'b1}}, {FW{1'b0}}};
      else
         result = {s1_sign_reg, {{(EW-1){1'b1}}, 1'b0}, {FW{1'b1}}};
   end

   // S2 register doubles as the output holding register while stalled.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         s2_valid_reg <= 1'b0;
         out_no       <= '0;
         out_flags    <= '0;
         out_tag      <= '0;
         out_rm_err   <= 1'b0;
      end else if (s2_advance) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_no     <= result;
            out_flags  <= {of_flag, uf_flag, nx_flag};
            out_tag    <= s1_tag_reg;
            out_rm_err <= s1_rm_err_reg;
         end
      end
   end

endmodule

// File: doc/fmadd_round_pipe.md
FMADD_ROUND_PIPE -- requirements
Module: fmadd_round_pipe

Interface
REQ-001 Parameter FW, default 23: fraction width (SP=23, DP=52).
REQ-002 Parameter EW, default 8: exponent width (SP=8, DP=11).
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 Derived widths: SW=2*FW+2 (product significand); IW=1+(EW+1)+SW; OW=1+EW+FW.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst_l  in  1  reset, synchronous and active-low.
REQ-007 in_valid  in  1  input operation valid.
REQ-008 in_ready  out  1  block accepts the input this cycle.
REQ-009 in_no  in  IW  packed input: {sign, exp[EW:0], sig[SW-1:0]}; exp[EW] is the pre-overflow bit.
REQ-010 in_sticky  in  1  sticky bit from the previous stage.
REQ-011 in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-012 in_tag  in  TAG_W  sideband tag, returned unchanged.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_no  out  OW  rounded result {sign, exp, frac}.
REQ-016 out_flags  out  3  {overflow, underflow, inexact}.
REQ-017 out_tag  out  TAG_W  tag of the result.
REQ-018 out_rm_err  out  1  in_rm was 101/110/111 for this result.

Function
REQ-019 Two-stage pipeline S1 (decode/increment decision) -> S2 (add/exception/flags); each stage has a valid register; latency is exactly 2 cycles with no stall.
REQ-020 Stage k advances when its own valid is 0 or the next stage accepts; S2 is accepted when out_ready=1; in_ready = ~s1_valid | s2_advance.
REQ-021 A transfer occurs only on valid&ready; with out_ready held 1 the block accepts one operation per cycle; order is preserved; no operation is dropped or duplicated.
REQ-022 Held outputs (out_no/flags/tag/rm_err) stay stable while out_valid=1 and out_ready=0.
REQ-023 Kept significand K=sig[SW-1:FW+1] (FW+1 bits, MSB=hidden); G=sig[FW]; R=sig[FW-1]; S=|sig[FW-2:0]; X=G|R|S|in_sticky.
REQ-024 Increment rules: RNE: G&(R|S|in_sticky|K[0]); RMM: G; RUP: X&~sign; RDN: X&sign; RTZ: never.
REQ-025 Reserved rm (101/110/111): treated as RNE, out_rm_err=1.
REQ-026 Rounded significand Kr=K+inc, computed FW+2 bits wide; exponent Er=exp[EW-1:0]+1 when Kr carries out, or when K[FW]=0 and Kr[FW]=1; otherwise Er=exp[EW-1:0].
REQ-027 Carry out -> fraction=0; otherwise fraction=Kr[FW-1:0].
REQ-028 Overflow (OF) = exp[EW] | (&exp[EW-1:0]) | (&Er) after rounding.
REQ-029 On OF: RNE/RMM/reserved, RUP with sign=0, or RDN with sign=1 -> {sign, all-ones, 0} (infinity); otherwise -> {sign, all-ones-1, all-ones} (max normal).
REQ-030 inexact = X | OF; underflow = (Er==0) & inexact & ~OF.
REQ-031 in_tag and the rm error bit travel with their operation through both stages.

Reset
REQ-032 While rst_l=0 at a clock edge: s1_valid, s2_valid, out_valid=0; out_no, out_flags, out_tag, out_rm_err=0; in_ready=0.
REQ-033 Reset asserted mid-operation discards all in-flight operations; the first cycle after rst_l=1 has in_ready=1 and out_valid=0.
REQ-034 No input is accepted in a cycle where rst_l=0.

Verification (SP defaults; exp shown as 9 bits, K as 24 bits)
REQ-035 sign0 exp 07F K FFFFFF G1 R0 S0, RNE -> out_no 40000000, flags 001, after 2 cycles.
REQ-036 sign0 exp 100, RTZ -> 7F7FFFFF, flags 101; same with RNE -> 7F800000, flags 101.
REQ-037 sign0 exp 0FE K FFFFFF G1, RNE -> 7F800000, flags 101 (overflow caused by rounding).
REQ-038 exp 000 K 000001 G1 R1, RNE -> 00000002, flags 011; sign0 exp 07F K 800000 GRS0 in_sticky1, RUP -> 3F800001, flags 001.
REQ-039 Backpressure: 4 back-to-back ops with out_ready=0 for 3 cycles -> in_ready drops once 2 are held; all 4 emerge in order with correct tags; stable outputs while stalled.
REQ-040 rst_l low for 1 cycle with 2 ops in flight -> both discarded, all outputs 0; then in_rm=111 op -> RNE result with out_rm_err=1.
